// File: rtl/frame_rd_pkg.sv
// Shared types and constants for the binary frame reader.
// Build option: FRAME_RD_PREFETCH_EN enables the one-word prefetch path in binary_frame_reader.
package frame_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    SHIFT = 2'd3
  } frame_rd_state_e;

  localparam int DEF_H_PIX  = 640;
  localparam int DEF_V_PIX  = 480;
  localparam int DEF_WORD_W = 16;

  // Number of SDRAM words that make up one binarized frame.
  function automatic int WORDS_PER_FRAME(input int h_pix, input int v_pix, input int word_w);
    return (h_pix * v_pix) / word_w;
  endfunction

endpackage

// File: rtl/pixel_unpacker.sv
// Holds one SDRAM word and hands it out MSB-first, one bit per accepted pixel.
// A load always wins over a shift so a new word can replace the last bit in the same cycle.
module pixel_unpacker
  import frame_rd_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              module_clk,
  input  logic              module_rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift_en,
  output logic              msb,
  output logic              last_bit
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;

  // Shift register and remaining-bit count; a load refills both, a shift consumes one bit.
  always_ff @(posedge module_clk) begin
    if (module_rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      bit_cnt   <= CNT_W'(WORD_W);
    end else if (shift_en) begin
      shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
      bit_cnt   <= bit_cnt - CNT_W'(1);
    end
  end

  assign msb      = shift_reg[WORD_W-1];
  assign last_bit = (bit_cnt == CNT_W'(1));

endmodule

// File: rtl/binary_frame_reader.sv
// Reads a binarized frame from the SDRAM read FIFO and streams it out as 1-bit pixels
// with line and frame markers. Build option: FRAME_RD_PREFETCH_EN adds a one-word
// holding register so the next word is fetched while the current one is shifting out.
module binary_frame_reader
  import frame_rd_pkg::*;
#(
  parameter int H_PIX  = DEF_H_PIX,
  parameter int V_PIX  = DEF_V_PIX,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              module_clk,
  input  logic              module_rst,
  input  logic              frame_start,
  input  logic              rd_ready,
  output logic              rd_req,
  input  logic [WORD_W-1:0] rd_data,
  input  logic              pix_ready,
  output logic              data_val,
  output logic              row_data,
  output logic              line_end,
  output logic              frame_end,
  output logic              busy
);

  localparam int COL_W = $clog2(H_PIX);
  localparam int ROW_W = $clog2(V_PIX);
  localparam int WORDS = WORDS_PER_FRAME(H_PIX, V_PIX, WORD_W);
  localparam int WL_W  = $clog2(WORDS + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIX - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_PIX - 1);
  localparam logic [WL_W-1:0]  WL_FULL  = WL_W'(WORDS);

  frame_rd_state_e state, state_nxt;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [WL_W-1:0]   words_left;
  logic              words_remain;
  logic              xfer;
  logic              last_bit;
  logic              unp_msb;
  logic              unp_load;
  logic [WORD_W-1:0] unp_load_data;

  assign words_remain = (words_left != '0);
  assign data_val     = (state == SHIFT);
  assign xfer         = data_val && pix_ready;
  assign row_data     = data_val && unp_msb;
  assign line_end     = data_val && (col == COL_LAST);
  assign frame_end    = line_end && (row == ROW_LAST);
  assign busy         = (state != IDLE);

`ifdef FRAME_RD_PREFETCH_EN
  logic [WORD_W-1:0] hold_word;
  logic              hold_valid;
  logic              in_flight;

  // Prefetch bookkeeping: a word requested during SHIFT lands in the holding register
  // unless the current word runs out that same cycle, in which case it goes straight
  // into the unpacker and the holding register stays empty.
  always_ff @(posedge module_clk) begin
    if (module_rst) begin
      hold_word  <= '0;
      hold_valid <= 1'b0;
      in_flight  <= 1'b0;
    end else begin
      in_flight <= rd_req;
      if (state == SHIFT && in_flight && !(xfer && last_bit)) begin
        hold_word  <= rd_data;
        hold_valid <= 1'b1;
      end else if (xfer && last_bit) begin
        hold_valid <= 1'b0;
      end
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge module_clk) begin
    if (module_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, read request and unpacker load decisions.
  always_comb begin
    state_nxt     = state;
    rd_req        = 1'b0;
    unp_load      = 1'b0;
    unp_load_data = rd_data;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (rd_ready) begin
          rd_req    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        unp_load  = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
`ifdef FRAME_RD_PREFETCH_EN
        rd_req = !hold_valid && !in_flight && words_remain && rd_ready;
        if (xfer && last_bit) begin
          if (hold_valid) begin
            unp_load      = 1'b1;
            unp_load_data = hold_word;
          end else if (in_flight) begin
            unp_load = 1'b1;
          end else if (rd_req) begin
            state_nxt = WAIT;
          end else if (words_remain) begin
            state_nxt = REQ;
          end else begin
            state_nxt = IDLE;
          end
        end
`else
        if (xfer && last_bit) begin
          state_nxt = words_remain ? REQ : IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame position and outstanding-word counters.
  always_ff @(posedge module_clk) begin
    if (module_rst) begin
      col        <= '0;
      row        <= '0;
      words_left <= '0;
    end else if (state == IDLE && frame_start) begin
      col        <= '0;
      row        <= '0;
      words_left <= WL_FULL;
    end else begin
      if (rd_req) begin
        words_left <= words_left - WL_W'(1);
      end
      if (xfer) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  pixel_unpacker #(
    .WORD_W(WORD_W)
  ) u_unpacker (
    .module_clk(module_clk),
    .module_rst(module_rst),
    .load      (unp_load),
    .load_data (unp_load_data),
    .shift_en  (xfer),
    .msb       (unp_msb),
    .last_bit  (last_bit)
  );

endmodule

// File: tb/tb_binary_frame_reader.sv
// Self-checking bench for binary_frame_reader on a small 32x2 frame of four words.
// Build option: FRAME_RD_PREFETCH_EN changes the expected valid-window length.
module tb_binary_frame_reader;

  localparam int H    = 32;
  localparam int V    = 2;
  localparam int W    = 16;
  localparam int NPIX = H * V;
  localparam int NWRD = NPIX / W;
`ifdef FRAME_RD_PREFETCH_EN
  localparam int EXP_SPAN = NPIX;
`else
  localparam int EXP_SPAN = NPIX + 2 * (NWRD - 1);
`endif

  logic         clk;
  logic         module_rst;
  logic         frame_start;
  logic         rd_ready;
  logic         rd_req;
  logic [W-1:0] rd_data;
  logic         pix_ready;
  logic         data_val;
  logic         row_data;
  logic         line_end;
  logic         frame_end;
  logic         busy;

  logic [W-1:0] words [NWRD];

  int errors;
  int checks;
  int cyc;

  int     req_count;
  int     xfer_count;
  int     le_count;
  int     fe_count;
  int     first_req_cyc;
  int     first_val_cyc;
  int     last_val_cyc;
  int     fe_cyc;
  bit     fe_seen;
  bit     prev_fe;
  bit     prev_hold;
  logic [NPIX-1:0] cap;

  bit     req_pending;
  int     rd_ptr;
  int     start_cyc;

  binary_frame_reader #(
    .H_PIX (H),
    .V_PIX (V),
    .WORD_W(W)
  ) dut (
    .module_clk (clk),
    .module_rst (module_rst),
    .frame_start(frame_start),
    .rd_ready   (rd_ready),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .pix_ready  (pix_ready),
    .data_val   (data_val),
    .row_data   (row_data),
    .line_end   (line_end),
    .frame_end  (frame_end),
    .busy       (busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure latencies relative to frame_start.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value against its required value and log any miss.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference pixel stream: pixel k is bit (W-1 - k mod W) of word k / W.
  function automatic logic modelPix(input int k);
    logic [W-1:0] w;
    w = words[k / W];
    return w[W - 1 - (k % W)];
  endfunction

  function automatic logic modelLineEnd(input int k);
    return (k % H) == (H - 1);
  endfunction

  function automatic logic modelFrameEnd(input int k);
    return k == (NPIX - 1);
  endfunction

  // Read FIFO model: a request seen in one cycle yields the next word in the following
  // cycle; at any other time the data bus carries a junk pattern that must never be used.
  always @(negedge clk) begin
    if (rd_req && !module_rst) req_pending = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    if (req_pending) begin
      rd_data     = words[rd_ptr % NWRD];
      rd_ptr      = rd_ptr + 1;
      req_pending = 1'b0;
    end else begin
      rd_data = 16'h5A3C;
    end
  end

  // Single compare process: every cycle the outputs carry a pixel, check it against the
  // model at the current transfer index and keep frame-level tallies.
  always @(negedge clk) begin
    if (module_rst) begin
      prev_fe   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_fe) checkOutput("busy_fall_after_frame_end", busy, 0);
      if (prev_hold) checkOutput("data_val_held", data_val, 1);
      prev_fe   = 1'b0;
      prev_hold = 1'b0;
      if (rd_req) begin
        req_count++;
        if (req_count == 1) first_req_cyc = cyc;
        checkOutput("rd_req_needs_rd_ready", rd_ready, 1);
      end
      if (data_val) begin
        if (first_val_cyc < 0) first_val_cyc = cyc;
        last_val_cyc = cyc;
        if (xfer_count < NPIX) begin
          checkOutput("row_data", row_data, modelPix(xfer_count));
          checkOutput("line_end", line_end, modelLineEnd(xfer_count));
          checkOutput("frame_end", frame_end, modelFrameEnd(xfer_count));
        end else begin
          checkOutput("pixel_overrun", xfer_count, NPIX - 1);
        end
        if (pix_ready) begin
          cap = {cap[NPIX-2:0], row_data};
          if (line_end) le_count++;
          if (frame_end) begin
            fe_count++;
            fe_cyc  = cyc;
            fe_seen = 1'b1;
            prev_fe = 1'b1;
            checkOutput("busy_at_frame_end", busy, 1);
          end
          xfer_count++;
        end else begin
          prev_hold = 1'b1;
        end
      end
    end
  end

  task automatic clearTallies();
    req_count     = 0;
    xfer_count    = 0;
    le_count      = 0;
    fe_count      = 0;
    first_req_cyc = -1;
    first_val_cyc = -1;
    last_val_cyc  = -1;
    fe_cyc        = 0;
    fe_seen       = 1'b0;
    cap           = '0;
    rd_ptr        = 0;
  endtask

  // Start one frame and drive rd_ready / pix_ready / an optional mid-frame restart pulse
  // until the frame has ended (bounded).
  task automatic applyStimulus(input int ready_delay, input bit toggle_ready, input bit restart_mid);
    int k;
    clearTallies();
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    start_cyc   = cyc;
    rd_ready    = (ready_delay == 0);
    pix_ready   = 1'b1;
    k = 0;
    while (!(fe_seen && cyc >= fe_cyc + 3) && k < 600) begin
      @(posedge clk);
      #1;
      k++;
      frame_start = restart_mid && (k == 40);
      rd_ready    = (k > ready_delay);
      pix_ready   = toggle_ready ? !pix_ready : 1'b1;
    end
    frame_start = 1'b0;
    rd_ready    = 1'b1;
    pix_ready   = 1'b1;
    checkOutput("frame_completed_in_time", fe_seen, 1);
  endtask

  // Frame-level expectations after a complete frame.
  task automatic checkFrame(input string tag, input int ready_delay, input bit check_span);
    $display("[TB] checking frame: %s", tag);
    checkOutput("transfer_count", xfer_count, NPIX);
    checkOutput("rd_req_count", req_count, NWRD);
    checkOutput("line_end_count", le_count, 2);
    checkOutput("frame_end_count", fe_count, 1);
    checkOutput("first_rd_req_cycle", first_req_cyc - start_cyc, 1 + ready_delay);
    checkOutput("first_pixel_cycle", first_val_cyc - start_cyc, 3 + ready_delay);
    checkOutput("stream_first_words", cap[63:32], 32'hA5F0_0001);
    checkOutput("stream_last_words", cap[31:0], 32'hFFFF_8000);
    if (check_span) checkOutput("valid_window_length", last_val_cyc - first_val_cyc + 1, EXP_SPAN);
  endtask

  task automatic checkAllZero(input string tag);
    $display("[TB] checking idle outputs: %s", tag);
    checkOutput("rd_req_zero", rd_req, 0);
    checkOutput("data_val_zero", data_val, 0);
    checkOutput("row_data_zero", row_data, 0);
    checkOutput("line_end_zero", line_end, 0);
    checkOutput("frame_end_zero", frame_end, 0);
    checkOutput("busy_zero", busy, 0);
  endtask

  // Directed scenario sequence.
  initial begin
    int k;
    errors      = 0;
    checks      = 0;
    req_pending = 1'b0;
    words[0]    = 16'hA5F0;
    words[1]    = 16'h0001;
    words[2]    = 16'hFFFF;
    words[3]    = 16'h8000;
    clearTallies();
    module_rst  = 1'b1;
    frame_start = 1'b0;
    rd_ready    = 1'b1;
    pix_ready   = 1'b1;
    rd_data     = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    module_rst = 1'b0;
    repeat (2) @(posedge clk);

    applyStimulus(0, 1'b0, 1'b0);
    checkFrame("basic frame", 0, 1'b1);

    applyStimulus(5, 1'b0, 1'b0);
    checkFrame("rd_ready low for 5 cycles", 5, 1'b0);

    applyStimulus(0, 1'b1, 1'b0);
    checkFrame("pix_ready toggling", 0, 1'b0);

    applyStimulus(0, 1'b0, 1'b1);
    checkFrame("frame_start reissued mid-frame", 0, 1'b1);

    // Reset in the cycle after the second read request, then a fresh frame.
    clearTallies();
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    rd_ready    = 1'b1;
    pix_ready   = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    k = 0;
    while (req_count < 2 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("second_rd_req_seen", req_count, 2);
    module_rst = 1'b1;
    @(posedge clk);
    #1;
    module_rst = 1'b0;
    @(negedge clk);
    checkAllZero("after mid-frame reset");
    repeat (3) @(posedge clk);

    applyStimulus(0, 1'b0, 1'b0);
    checkFrame("clean frame after reset", 0, 1'b1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/binary_frame_reader.md
# binary_frame_reader

Streams a binarized frame back out of SDRAM for the morphology stage. On `frame_start` it issues read requests to the SDRAM read-FIFO port, captures each 16-bit word one cycle after its request, and unpacks it MSB-first into a 1-bit pixel stream (`data_val` / `row_data`) with line and frame markers. It is the read-side counterpart of the morphology block's SDRAM write request and sits between the SDRAM read FIFO and the morphology input.

## Interface
- `H_PIX`, 640, pixels per line; must be a multiple of `WORD_W`.
- `V_PIX`, 480, lines per frame.
- `WORD_W`, 16, SDRAM word width in bits.
- `module_clk`  in  1  system clock; all logic is on its rising edge.
- `module_rst`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  single-cycle pulse that starts a frame read; ignored while `busy`.
- `rd_ready`  in  1  read FIFO holds at least one word.
- `rd_req`  out  1  one-cycle read request; asserted only when `rd_ready` is high.
- `rd_data`  in  WORD_W  read data; valid exactly one cycle after `rd_req`.
- `pix_ready`  in  1  downstream accepts a pixel.
- `data_val`  out  1  pixel valid.
- `row_data`  out  1  pixel value.
- `line_end`  out  1  qualifies the last pixel of a line.
- `frame_end`  out  1  qualifies the last pixel of a frame.
- `busy`  out  1  a frame read is in progress.

## Operation
- FSM states: IDLE, REQ, WAIT, SHIFT.
- IDLE: on `frame_start`, clear the counters, set `busy`, and go to REQ.
- REQ: while `rd_ready` is low, stay in REQ with `rd_req` low. When `rd_ready` is high, pulse `rd_req` for one cycle, decrement `words_left`, and go to WAIT.
- WAIT: unconditionally capture `rd_data` into the shift register, set `bit_cnt` to `WORD_W`, and go to SHIFT.
- SHIFT:
  - `data_val` is high and `row_data` = shift register MSB.
  - A pixel transfers when `data_val && pix_ready`. On each transfer, shift left by 1, decrement `bit_cnt`, and advance `col`/`row`.
  - After the last bit of a word transfers: if `words_left` > 0, go to REQ; otherwise clear `busy` and go to IDLE.
- Backpressure: while `pix_ready` is low, `data_val`, `row_data`, `line_end` and `frame_end` hold their values.
- Counters:
  - `col` is `$clog2(H_PIX)` bits and wraps H_PIX-1 → 0, incrementing `row`.
  - `row` is `$clog2(V_PIX)` bits.
  - `words_left` is `$clog2(H_PIX*V_PIX/WORD_W+1)` bits.
- `line_end` = `data_val && col==H_PIX-1`. `frame_end` = `line_end && row==V_PIX-1`.
- `frame_start` while busy is ignored; no restart and no error.
- Reset at any time:
  - Go to IDLE; all outputs and counters go to 0.
  - A word whose request is in flight is discarded.
  - Downstream must treat a `data_val` drop without `frame_end` as an aborted frame.

## Timing
- Reset values: `rd_req`, `data_val`, `row_data`, `line_end`, `frame_end` and `busy` are all 0.
- Frame start (`rd_ready` high):
  - `frame_start` in cycle 0 → `busy` and REQ in cycle 1, `rd_req` in cycle 1.
  - `rd_data` is sampled in cycle 2.
  - First pixel (bit 15) is valid in cycle 3.
- Without prefetch, each word gives 16 valid cycles followed by a 2-cycle gap (REQ, WAIT). Peak throughput is 16 pixels per 18 cycles.
- `busy` falls in the cycle after the `frame_end` transfer.

## Configuration
- Macro: `FRAME_RD_PREFETCH_EN`.
- Defined:
  - Adds a one-word holding register plus a valid flag.
  - `rd_req` issues during SHIFT whenever the holding register is empty, no request is in flight, `words_left` > 0, and `rd_ready` is high.
  - The last-bit transfer loads the holding word directly into the shift register, with no gap.
  - With `rd_ready` continuously high and `pix_ready` high, the output is 1 pixel per cycle for the whole frame: a 640×480 frame takes 307200 valid cycles plus 3 cycles of startup latency.
- Undefined: REQ/WAIT gap behaviour as described above.

## Structure
- Package `frame_rd_pkg` holds:
  - the FSM state enum (IDLE/REQ/WAIT/SHIFT);
  - default `H_PIX`, `V_PIX` and `WORD_W` constants;
  - a `WORDS_PER_FRAME` constant function.
- Sub-module `pixel_unpacker` contains the shift register, `bit_cnt`, load/shift controls and the `last_bit` flag. The top level keeps the FSM, request logic, counters and markers.

## Test plan
- H_PIX=32, V_PIX=2, `rd_ready`=1, `pix_ready`=1, `frame_start` pulse, words 0xA5F0, 0x0001, 0xFFFF, 0x8000:
  - `row_data` sequence is 1010_0101_1111_0000, then 0000_0000_0000_0001, …;
  - `line_end` on pixels 31 and 63, `frame_end` on pixel 63;
  - exactly 4 `rd_req` pulses, and `busy` falls 1 cycle after the last pixel.
- Same frame, `rd_ready` held low for 5 cycles after start → `rd_req` delayed 5 cycles, no spurious request, output data unchanged.
- `pix_ready` toggling 1/0 every cycle → each pixel is held while `pix_ready`=0; 64 transfers total; the sequence matches scenario 1.
- `frame_start` reissued mid-frame → ignored; exactly 4 requests and one `frame_end`.
- `module_rst` asserted in the cycle after the 2nd `rd_req`:
  - all outputs are 0 next cycle and the in-flight word is dropped;
  - a new `frame_start` then reads a clean 4-word frame.
- With `FRAME_RD_PREFETCH_EN`: scenario 1 gives `data_val` continuously high for 64 cycles starting at cycle 3, with no gaps.
